// File: rtl/jelly_button_reader.sv
// Push-button reader: 2-flop synchroniser, debounce FSM, press/release pulses and press counter.
// Optional long-press detector enabled by defining JELLY_BTN_LONG_PRESS_EN.
`timescale 1ns/1ps

module jelly_button_reader #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 8,
    parameter int LONG_CYCLES     = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             clr_count,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic             s1_reg, s2_reg;
    state_t           state_reg, state_next;
    logic [DBC_W-1:0] dbc_reg, dbc_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Only s2_reg may be looked at by the FSM; s1_reg may be metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= btn_raw;
            s2_reg <= s1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_LOW;
            dbc_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            dbc_reg     <= dbc_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dbc_next     = dbc_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;

        case (state_reg)
            S_LOW: begin
                if (s2_reg) begin
                    state_next = S_RISE;
                    dbc_next   = DBC_W'(1);
                end
            end
            S_RISE: begin
                if (!s2_reg) begin
                    state_next = S_LOW;
                    dbc_next   = '0;
                end else if (dbc_reg == DBC_LAST) begin
                    state_next = S_HIGH;
                    dbc_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    dbc_next = dbc_reg + DBC_W'(1);
                end
            end
            S_HIGH: begin
                if (!s2_reg) begin
                    state_next = S_FALL;
                    dbc_next   = DBC_W'(1);
                end
            end
            S_FALL: begin
                if (s2_reg) begin
                    state_next = S_HIGH;
                    dbc_next   = '0;
                end else if (dbc_reg == DBC_LAST) begin
                    state_next   = S_LOW;
                    dbc_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    dbc_next = dbc_reg + DBC_W'(1);
                end
            end
            default: begin
                state_next = S_LOW;
                dbc_next   = '0;
            end
        endcase
    end

    // Clear first, then count, so a press coinciding with a clear is never lost.
    always_comb begin
        count_next = clr_count ? '0 : count_reg;
        if (press_next) begin
            count_next = count_next + CNT_W'(1);
        end
    end

    assign btn_level     = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign press_count   = count_reg;

`ifdef JELLY_BTN_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt_reg, long_cnt_next;
    logic              long_reg, long_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_reg <= '0;
            long_reg     <= 1'b0;
        end else begin
            long_cnt_reg <= long_cnt_next;
            long_reg     <= long_next;
        end
    end

    // Counter saturates at LONG_MAX so the pulse fires at most once per press;
    // an S_FALL bounce back to S_HIGH keeps the count.
    always_comb begin
        long_cnt_next = long_cnt_reg;
        long_next     = 1'b0;
        if (state_next == S_LOW) begin
            long_cnt_next = '0;
        end else if ((state_reg == S_HIGH || state_reg == S_FALL) &&
                     long_cnt_reg != LONG_MAX) begin
            long_cnt_next = long_cnt_reg + LONG_W'(1);
            long_next     = (long_cnt_reg == LONG_MAX - LONG_W'(1));
        end
    end

    assign long_pulse = long_reg;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_jelly_button_reader.sv
// Scoreboard bench for jelly_button_reader: stimulus pushes expected pulses,
// a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps

module tb_jelly_button_reader;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int LONG = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_raw = 1'b0;
    logic          clr_count = 1'b0;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic [CW-1:0] press_count;

    jelly_button_reader #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .clr_count     (clr_count),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // kind: 0 = press, 1 = release, 2 = long; at < 0 means timing not checked
    typedef struct {
        int kind;
        int cnt;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  model_cnt = 0;
    int  long_seen = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s value=%0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int kind, input int cnt, input int at);
        ev_t e;
        e.kind = kind;
        e.cnt  = cnt;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge: first sampling edge is cyc+1, pulse after edge cyc+1+DEB+1.
    task automatic do_press();
        btn_raw   = 1'b1;
        model_cnt = (model_cnt + 1) % (1 << CW);
        push(0, model_cnt, cyc + DEB + 2);
        repeat (DEB + 5) @(negedge clk);
    endtask

    task automatic do_release();
        btn_raw = 1'b0;
        push(1, model_cnt, cyc + DEB + 2);
        repeat (DEB + 5) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && (press_pulse || release_pulse || long_pulse)) begin
            int  kind;
            ev_t e;
            total++;
            if (press_pulse && release_pulse) begin
                bad++;
                $display("FAIL pulse_overlap press=%0b release=%0b required both not set (cycle %0d)",
                         press_pulse, release_pulse, cyc);
            end
            kind = press_pulse ? 0 : (release_pulse ? 1 : 2);
            if (kind == 2) long_seen++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse kind=%0d count=%0d required no pulse (cycle %0d)",
                         kind, press_count, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind || e.cnt != int'(press_count) || (e.at >= 0 && e.at != cyc)) begin
                    bad++;
                    $display("FAIL pulse_event actual kind=%0d count=%0d cycle=%0d required kind=%0d count=%0d cycle=%0d",
                             kind, press_count, cyc, e.kind, e.cnt, e.at);
                end else begin
                    $display("ok   pulse_event kind=%0d count=%0d cycle=%0d", kind, press_count, cyc);
                end
            end
        end
    end

    initial begin
        int p;

        // 1: reset with button held, then debounce to first press
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_long", long_pulse, 0);
        check("rst_count", press_count, 0);
        rst_n     = 1'b1;
        model_cnt = 1;
        push(0, 1, cyc + DEB + 2);
        repeat (DEB + 5) @(negedge clk);
        check("t1_level", btn_level, 1);
        check("t1_count", press_count, 1);
        do_release();
        check("t1_level_released", btn_level, 0);

        // 2: bounces of 3 synced samples never qualify
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            repeat (3) @(negedge clk);
            btn_raw = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("t2_level_after_bounce", btn_level, 0);
        check("t2_count_after_bounce", press_count, model_cnt);
        do_press();
        check("t2_level_held", btn_level, 1);
        do_release();

        // 3: clear, then 17 press/release cycles wrap the 4-bit counter
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        model_cnt = 0;
        check("t3_clear", press_count, 0);
        for (int i = 0; i < 17; i++) begin
            do_press();
            do_release();
        end
        check("t3_wrap_count", press_count, 1);

        // 4: clear on the press edge keeps the press; clear alone zeroes
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        model_cnt = 0;
        check("t4_clear_idle", press_count, 0);
        btn_raw   = 1'b1;
        p         = cyc + DEB + 2;
        model_cnt = 1;
        push(0, 1, p);
        repeat (DEB + 1) @(negedge clk);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        check("t4_clear_with_press", press_count, 1);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        model_cnt = 0;
        check("t4_clear_alone", press_count, 0);
        repeat (3) @(negedge clk);
        do_release();

        // 5: long hold with a short dropout before the long threshold
        btn_raw   = 1'b1;
        p         = cyc + DEB + 2;
        model_cnt = model_cnt + 1;
        push(0, model_cnt, p);
`ifdef JELLY_BTN_LONG_PRESS_EN
        push(2, model_cnt, p + LONG);
`endif
        repeat (12) @(negedge clk);
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw = 1'b1;
        repeat (32) @(negedge clk);
        check("t5_level_held", btn_level, 1);
        do_release();
`ifdef JELLY_BTN_LONG_PRESS_EN
        check("t5_long_count", long_seen, 1);
`else
        check("t5_long_count", long_seen, 0);
`endif

        // 6: asynchronous reset while held, then re-debounce
        do_press();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_level", btn_level, 0);
        check("t6_async_count", press_count, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        model_cnt = 1;
        push(0, 1, cyc + DEB + 2);
        repeat (DEB + 5) @(negedge clk);
        check("t6_level", btn_level, 1);
        check("t6_count", press_count, 1);
        do_release();

        repeat (10) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
